// File: rtl/ex_mem_branch_stage_if.sv
// EX->MEM boundary bundle: EX-side operation fields in, MEM-side registered fields,
// flag register and branch redirect out.
interface ex_mem_branch_stage_if #(
    parameter int DATA_W = 16,
    parameter int PC_W   = 16,
    parameter int REG_W  = 4
);
    logic              stall;
    logic              ex_valid;
    logic [3:0]        ex_op;
    logic [DATA_W-1:0] ex_alu_out;
    logic              ex_zero;
    logic              ex_negative;
    logic [DATA_W-1:0] ex_store_data;
    logic [REG_W-1:0]  ex_rd;
    logic              ex_reg_write;
    logic              ex_mem_read;
    logic              ex_mem_write;
    logic [PC_W-1:0]   ex_branch_target;

    logic              mem_valid;
    logic [DATA_W-1:0] mem_alu_out;
    logic [DATA_W-1:0] mem_store_data;
    logic [REG_W-1:0]  mem_rd;
    logic              mem_reg_write;
    logic              mem_mem_read;
    logic              mem_mem_write;
    logic              flag_z;
    logic              flag_n;
    logic              branch_taken;
    logic [PC_W-1:0]   branch_pc;
    logic              flush;

    modport slave (
        input  stall, ex_valid, ex_op, ex_alu_out, ex_zero, ex_negative, ex_store_data,
               ex_rd, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch_target,
        output mem_valid, mem_alu_out, mem_store_data, mem_rd, mem_reg_write,
               mem_mem_read, mem_mem_write, flag_z, flag_n, branch_taken, branch_pc, flush
    );

    modport master (
        output stall, ex_valid, ex_op, ex_alu_out, ex_zero, ex_negative, ex_store_data,
               ex_rd, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch_target,
        input  mem_valid, mem_alu_out, mem_store_data, mem_rd, mem_reg_write,
               mem_mem_read, mem_mem_write, flag_z, flag_n, branch_taken, branch_pc, flush
    );
endinterface

// File: rtl/ex_mem_branch_stage.sv
// EX->MEM pipeline register with Z/N flag register and B/BEQ/BGE resolution.
// A taken branch pulses a redirect and drops the next BR_SHADOW wrong-path ops.
module ex_mem_branch_stage #(
    parameter int DATA_W    = 16,
    parameter int PC_W      = 16,
    parameter int REG_W     = 4,
    parameter int BR_SHADOW = 1
) (
    input logic                  clk,
    input logic                  rst,
    ex_mem_branch_stage_if.slave bus
);
    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0010;
    localparam logic [3:0] OP_OR  = 4'b0011;
    localparam logic [3:0] OP_CMP = 4'b0101;
    localparam logic [3:0] OP_SET = 4'b0110;
    localparam logic [3:0] OP_LDR = 4'b0111;
    localparam logic [3:0] OP_STR = 4'b1000;
    localparam logic [3:0] OP_B   = 4'b1001;
    localparam logic [3:0] OP_BEQ = 4'b1010;
    localparam logic [3:0] OP_BGE = 4'b1011;
    localparam logic [1:0] SHADOW_INIT = 2'(BR_SHADOW);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_SQUASH = 1'b1
    } state_t;

    state_t            state_r;
    state_t            state_nxt_s;
    logic [1:0]        cnt_r;
    logic [1:0]        cnt_nxt_s;

    logic              mem_valid_r;
    logic [DATA_W-1:0] mem_alu_out_r;
    logic [DATA_W-1:0] mem_store_data_r;
    logic [REG_W-1:0]  mem_rd_r;
    logic              mem_reg_write_r;
    logic              mem_mem_read_r;
    logic              mem_mem_write_r;
    logic              flag_z_r;
    logic              flag_n_r;
    logic              branch_taken_r;
    logic [PC_W-1:0]   branch_pc_r;

    logic              is_alu_s;
    logic              is_ctl_s;
    logic              is_cmp_s;
    logic              cond_s;
    logic              advance_s;
    logic              live_s;
    logic              drop_s;
    logic              take_s;

    // Opcode decode and branch condition against the current flag register
    always_comb begin
        is_alu_s = 1'b0;
        is_ctl_s = 1'b0;
        is_cmp_s = 1'b0;
        cond_s   = 1'b0;
        case (bus.ex_op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SET, OP_LDR, OP_STR: is_alu_s = 1'b1;
            OP_CMP: begin
                is_ctl_s = 1'b1;
                is_cmp_s = 1'b1;
            end
            OP_B: begin
                is_ctl_s = 1'b1;
                cond_s   = 1'b1;
            end
            OP_BEQ: begin
                is_ctl_s = 1'b1;
                cond_s   = flag_z_r;
            end
            OP_BGE: begin
                is_ctl_s = 1'b1;
                cond_s   = ~flag_n_r;
            end
            default: begin
                is_alu_s = 1'b0;
                is_ctl_s = 1'b0;
            end
        endcase
    end

    assign advance_s = ~bus.stall;
    assign live_s    = advance_s & bus.ex_valid & (state_r == ST_IDLE);
    assign drop_s    = advance_s & bus.ex_valid & (state_r == ST_SQUASH);
    assign take_s    = live_s & cond_s;

    // Squash FSM next state: count down only on dropped valid ops
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (take_s) begin
                    state_nxt_s = ST_SQUASH;
                    cnt_nxt_s   = SHADOW_INIT;
                end else begin
                    cnt_nxt_s   = 2'd0;
                end
            end
            ST_SQUASH: begin
                if (drop_s) begin
                    cnt_nxt_s = cnt_r - 2'd1;
                    if (cnt_r <= 2'd1) begin
                        state_nxt_s = ST_IDLE;
                    end else begin
                        state_nxt_s = ST_SQUASH;
                    end
                end else begin
                    cnt_nxt_s = cnt_r;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = 2'd0;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= 2'd0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Pipeline, flag and redirect registers; the redirect pulse clears even while stalled
    always_ff @(posedge clk) begin
        if (!rst) begin
            mem_valid_r      <= 1'b0;
            mem_alu_out_r    <= {DATA_W{1'b0}};
            mem_store_data_r <= {DATA_W{1'b0}};
            mem_rd_r         <= {REG_W{1'b0}};
            mem_reg_write_r  <= 1'b0;
            mem_mem_read_r   <= 1'b0;
            mem_mem_write_r  <= 1'b0;
            flag_z_r         <= 1'b0;
            flag_n_r         <= 1'b0;
            branch_taken_r   <= 1'b0;
            branch_pc_r      <= {PC_W{1'b0}};
        end else begin
            branch_taken_r <= take_s;
            if (take_s) begin
                branch_pc_r <= bus.ex_branch_target;
            end
            if (live_s && is_cmp_s) begin
                flag_z_r <= bus.ex_zero;
                flag_n_r <= bus.ex_negative;
            end
            if (advance_s) begin
                if (live_s && (is_alu_s || is_ctl_s)) begin
                    mem_valid_r      <= 1'b1;
                    mem_alu_out_r    <= bus.ex_alu_out;
                    mem_store_data_r <= bus.ex_store_data;
                    mem_rd_r         <= bus.ex_rd;
                    mem_reg_write_r  <= bus.ex_reg_write & is_alu_s;
                    mem_mem_read_r   <= bus.ex_mem_read & is_alu_s;
                    mem_mem_write_r  <= bus.ex_mem_write & is_alu_s;
                end else begin
                    mem_valid_r      <= 1'b0;
                    mem_alu_out_r    <= {DATA_W{1'b0}};
                    mem_store_data_r <= {DATA_W{1'b0}};
                    mem_rd_r         <= {REG_W{1'b0}};
                    mem_reg_write_r  <= 1'b0;
                    mem_mem_read_r   <= 1'b0;
                    mem_mem_write_r  <= 1'b0;
                end
            end
        end
    end

    assign bus.mem_valid      = mem_valid_r;
    assign bus.mem_alu_out    = mem_alu_out_r;
    assign bus.mem_store_data = mem_store_data_r;
    assign bus.mem_rd         = mem_rd_r;
    assign bus.mem_reg_write  = mem_reg_write_r;
    assign bus.mem_mem_read   = mem_mem_read_r;
    assign bus.mem_mem_write  = mem_mem_write_r;
    assign bus.flag_z         = flag_z_r;
    assign bus.flag_n         = flag_n_r;
    assign bus.branch_taken   = branch_taken_r;
    assign bus.branch_pc      = branch_pc_r;
    assign bus.flush          = branch_taken_r;
endmodule

// File: tb/tb_ex_mem_branch_stage.sv
// Bench for ex_mem_branch_stage: directed scenarios plus a randomized run against
// an instruction-level reference model of the stage.
module tb_ex_mem_branch_stage;
    localparam int DATA_W    = 16;
    localparam int PC_W      = 16;
    localparam int REG_W     = 4;
    localparam int BR_SHADOW = 1;
    localparam int VEC_W     = 2 * DATA_W + REG_W + PC_W + 8;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    ex_mem_branch_stage_if #(.DATA_W(DATA_W), .PC_W(PC_W), .REG_W(REG_W)) bus ();

    ex_mem_branch_stage #(
        .DATA_W(DATA_W), .PC_W(PC_W), .REG_W(REG_W), .BR_SHADOW(BR_SHADOW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state: what MEM should hold after the last edge
    logic              m_valid, m_rw, m_mr, m_mw, m_z, m_n, m_bt;
    logic [DATA_W-1:0] m_alu, m_sd;
    logic [REG_W-1:0]  m_rd;
    logic [PC_W-1:0]   m_pc;
    int                m_left;

    function automatic logic [VEC_W-1:0] dut_vec();
        return {bus.mem_valid, bus.mem_alu_out, bus.mem_store_data, bus.mem_rd,
                bus.mem_reg_write, bus.mem_mem_read, bus.mem_mem_write,
                bus.flag_z, bus.flag_n, bus.branch_taken, bus.branch_pc, bus.flush};
    endfunction

    function automatic logic [VEC_W-1:0] model_vec();
        return {m_valid, m_alu, m_sd, m_rd, m_rw, m_mr, m_mw, m_z, m_n, m_bt, m_pc, m_bt};
    endfunction

    task automatic model_edge();
        int  op;
        bit  alu_class, ctl_class, taken;
        op        = int'(bus.ex_op);
        alu_class = (op inside {0, 1, 2, 3, 6, 7, 8});
        ctl_class = (op inside {5, 9, 10, 11});
        if (!rst) begin
            {m_valid, m_rw, m_mr, m_mw, m_z, m_n, m_bt} = '0;
            m_alu = '0; m_sd = '0; m_rd = '0; m_pc = '0; m_left = 0;
        end else begin
            m_bt = 1'b0;
            if (!bus.stall) begin
                if (bus.ex_valid && m_left > 0) begin
                    m_left = m_left - 1;
                    m_valid = 1'b0; m_alu = '0; m_sd = '0; m_rd = '0;
                    {m_rw, m_mr, m_mw} = '0;
                end else if (bus.ex_valid && (alu_class || ctl_class)) begin
                    m_valid = 1'b1;
                    m_alu = bus.ex_alu_out; m_sd = bus.ex_store_data; m_rd = bus.ex_rd;
                    m_rw = alu_class && bus.ex_reg_write;
                    m_mr = alu_class && bus.ex_mem_read;
                    m_mw = alu_class && bus.ex_mem_write;
                    taken = (op == 9) || (op == 10 && m_z) || (op == 11 && !m_n);
                    if (op == 5) begin
                        m_z = bus.ex_zero;
                        m_n = bus.ex_negative;
                    end
                    if (taken) begin
                        m_bt = 1'b1;
                        m_pc = bus.ex_branch_target;
                        m_left = BR_SHADOW;
                    end
                end else begin
                    m_valid = 1'b0; m_alu = '0; m_sd = '0; m_rd = '0;
                    {m_rw, m_mr, m_mw} = '0;
                end
            end
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] op, input logic [DATA_W-1:0] alu,
                         input logic [REG_W-1:0] rd, input logic rw, input logic mw,
                         input logic z, input logic n, input logic [PC_W-1:0] tgt);
        bus.ex_valid = 1'b1; bus.ex_op = op; bus.ex_alu_out = alu; bus.ex_rd = rd;
        bus.ex_reg_write = rw; bus.ex_mem_read = 1'b0; bus.ex_mem_write = mw;
        bus.ex_zero = z; bus.ex_negative = n; bus.ex_branch_target = tgt;
        bus.ex_store_data = 16'h00A5;
    endtask

    task automatic test_reset();
        rst = 1'b0; bus.stall = 1'b0;
        drive(4'b0000, 16'hABCD, 4'd2, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0010);
        for (int i = 0; i < 2; i++) begin
            tick();
            vectors++;
            if (dut_vec() !== {VEC_W{1'b0}}) begin
                miscompares++;
                $display("FAIL reset_outputs: got %h want 0", dut_vec());
            end
        end
        rst = 1'b1;
        tick();
        vectors++;
        if (bus.mem_valid !== 1'b1 || bus.mem_alu_out !== 16'hABCD) begin
            miscompares++;
            $display("FAIL reset_release_add: got valid=%b alu=%h want 1 abcd",
                     bus.mem_valid, bus.mem_alu_out);
        end
    endtask

    task automatic test_add();
        drive(4'b0000, 16'h1234, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
        tick();
        vectors++;
        if ({bus.mem_valid, bus.mem_alu_out, bus.mem_rd, bus.mem_reg_write, bus.flag_z, bus.flag_n}
            !== {1'b1, 16'h1234, 4'd3, 1'b1, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL add_pass: got v=%b alu=%h rd=%0d rw=%b z=%b n=%b want 1 1234 3 1 0 0",
                     bus.mem_valid, bus.mem_alu_out, bus.mem_rd, bus.mem_reg_write,
                     bus.flag_z, bus.flag_n);
        end
    endtask

    task automatic test_beq_taken();
        drive(4'b0101, 16'h0000, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
        tick();
        vectors++;
        if (bus.flag_z !== 1'b1) begin
            miscompares++;
            $display("FAIL cmp_flag_z: got %b want 1", bus.flag_z);
        end
        drive(4'b1010, 16'h0000, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0040);
        tick();
        vectors++;
        if ({bus.branch_taken, bus.flush, bus.branch_pc} !== {1'b1, 1'b1, 16'h0040}) begin
            miscompares++;
            $display("FAIL beq_pulse: got bt=%b fl=%b pc=%h want 1 1 0040",
                     bus.branch_taken, bus.flush, bus.branch_pc);
        end
        drive(4'b0000, 16'h1111, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
        tick();
        vectors++;
        if ({bus.mem_valid, bus.branch_taken, bus.branch_pc} !== {1'b0, 1'b0, 16'h0040}) begin
            miscompares++;
            $display("FAIL beq_squash: got v=%b bt=%b pc=%h want 0 0 0040",
                     bus.mem_valid, bus.branch_taken, bus.branch_pc);
        end
        drive(4'b0000, 16'h2222, 4'd2, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
        tick();
        vectors++;
        if (bus.mem_valid !== 1'b1 || bus.mem_alu_out !== 16'h2222) begin
            miscompares++;
            $display("FAIL beq_after_shadow: got v=%b alu=%h want 1 2222",
                     bus.mem_valid, bus.mem_alu_out);
        end
    endtask

    task automatic test_bge_not_taken();
        drive(4'b0101, 16'h0000, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
        tick();
        vectors++;
        if (bus.flag_n !== 1'b1 || bus.flag_z !== 1'b0) begin
            miscompares++;
            $display("FAIL cmp_flag_n: got z=%b n=%b want 0 1", bus.flag_z, bus.flag_n);
        end
        drive(4'b1011, 16'h0000, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0080);
        tick();
        vectors++;
        if (bus.branch_taken !== 1'b0 || bus.mem_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL bge_not_taken: got bt=%b v=%b want 0 1", bus.branch_taken, bus.mem_valid);
        end
        drive(4'b0000, 16'h3333, 4'd4, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
        tick();
        vectors++;
        if (bus.mem_valid !== 1'b1 || bus.mem_alu_out !== 16'h3333) begin
            miscompares++;
            $display("FAIL bge_no_squash: got v=%b alu=%h want 1 3333", bus.mem_valid, bus.mem_alu_out);
        end
    endtask

    task automatic test_stall();
        drive(4'b0001, 16'h5555, 4'd5, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
        tick();
        bus.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(4'(i), 16'($urandom), 4'(i + 7), 1'b0, 1'b1, 1'b1, 1'b1, 16'h0000);
            tick();
            vectors++;
            if ({bus.mem_valid, bus.mem_alu_out, bus.mem_rd, bus.mem_reg_write, bus.flag_z}
                !== {1'b1, 16'h5555, 4'd5, 1'b1, 1'b0}) begin
                miscompares++;
                $display("FAIL stall_hold: got v=%b alu=%h rd=%0d rw=%b z=%b want 1 5555 5 1 0",
                         bus.mem_valid, bus.mem_alu_out, bus.mem_rd, bus.mem_reg_write, bus.flag_z);
            end
        end
        bus.stall = 1'b0;
        drive(4'b0101, 16'h7777, 4'd6, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
        tick();
        vectors++;
        if ({bus.mem_valid, bus.mem_reg_write, bus.mem_mem_write, bus.mem_alu_out}
            !== {1'b1, 1'b0, 1'b0, 16'h7777}) begin
            miscompares++;
            $display("FAIL cmp_forced_enables: got v=%b rw=%b mw=%b alu=%h want 1 0 0 7777",
                     bus.mem_valid, bus.mem_reg_write, bus.mem_mem_write, bus.mem_alu_out);
        end
    endtask

    task automatic test_pulse_under_stall();
        drive(4'b1001, 16'h0000, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0ACE);
        tick();
        bus.stall = 1'b1;
        drive(4'b0000, 16'h4444, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
        tick();
        vectors++;
        if (bus.branch_taken !== 1'b0 || bus.branch_pc !== 16'h0ACE) begin
            miscompares++;
            $display("FAIL pulse_one_cycle: got bt=%b pc=%h want 0 0ace", bus.branch_taken, bus.branch_pc);
        end
        bus.stall = 1'b0;
        tick();
        vectors++;
        if (bus.mem_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL squash_after_stall: got v=%b want 0", bus.mem_valid);
        end
    endtask

    task automatic test_reset_in_squash();
        drive(4'b1001, 16'h0000, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0100);
        tick();
        rst = 1'b0;
        drive(4'b0000, 16'h6666, 4'd6, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
        tick();
        vectors++;
        if (dut_vec() !== {VEC_W{1'b0}}) begin
            miscompares++;
            $display("FAIL reset_mid_squash: got %h want 0", dut_vec());
        end
        rst = 1'b1;
        tick();
        vectors++;
        if (bus.mem_valid !== 1'b1 || bus.branch_taken !== 1'b0) begin
            miscompares++;
            $display("FAIL add_after_reset: got v=%b bt=%b want 1 0", bus.mem_valid, bus.branch_taken);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            rst                  = ($urandom_range(0, 59) != 0);
            bus.stall            = ($urandom_range(0, 4) == 0);
            bus.ex_valid         = ($urandom_range(0, 4) != 0);
            bus.ex_op            = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(9, 11))
                                                               : 4'($urandom_range(0, 15));
            bus.ex_alu_out       = 16'($urandom);
            bus.ex_store_data    = 16'($urandom);
            bus.ex_rd            = 4'($urandom);
            bus.ex_reg_write     = 1'($urandom);
            bus.ex_mem_read      = 1'($urandom);
            bus.ex_mem_write     = 1'($urandom);
            bus.ex_zero          = 1'($urandom);
            bus.ex_negative      = 1'($urandom);
            bus.ex_branch_target = 16'($urandom);
            tick();
            vectors++;
            if (dut_vec() !== model_vec()) begin
                miscompares++;
                $display("FAIL random_cycle_%0d: got %h want %h", i, dut_vec(), model_vec());
            end
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        m_left = 0;
        {m_valid, m_rw, m_mr, m_mw, m_z, m_n, m_bt} = '0;
        m_alu = '0; m_sd = '0; m_rd = '0; m_pc = '0;
        bus.ex_mem_read = 1'b0;
        test_reset();
        test_add();
        test_beq_taken();
        test_bge_not_taken();
        test_stall();
        test_pulse_under_stall();
        test_reset_in_squash();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
